// File: rtl/minmax_pkg.sv
// Shared state encoding and default sizing for the window_minmax tracker.
package minmax_pkg;

  localparam int N_DEF   = 8;
  localparam int WIN_DEF = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ACC   = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/comp.sv
// Unsigned N-bit magnitude comparator: exactly one of gt/eq/lt is high.
module comp #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         gt_o,
  output logic         eq_o,
  output logic         lt_o
);

  assign gt_o = (a_i >  b_i);
  assign eq_o = (a_i == b_i);
  assign lt_o = (a_i <  b_i);

endmodule

// File: rtl/window_minmax.sv
// Streaming windowed min/max tracker with valid/ready in and out.
// Optional max-tie counter enabled by defining WINDOW_MINMAX_TIES_EN.
module window_minmax
  import minmax_pkg::*;
#(
  parameter  int N     = N_DEF,
  parameter  int WIN   = WIN_DEF,
  localparam int CNT_W = $clog2(WIN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_max,
  output logic [N-1:0]     out_min,
  output logic [CNT_W-1:0] out_count
`ifdef WINDOW_MINMAX_TIES_EN
  ,
  output logic [CNT_W-1:0] out_max_ties
`endif
);

  state_e           state_q, state_d;
  logic [N-1:0]     max_q, max_d;
  logic [N-1:0]     min_q, min_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_s;
  logic             max_gt, max_eq, max_lt;
  logic             min_gt, min_eq, min_lt;
  logic             cmp_unused;

  comp #(.N(N)) u_cmp_max (
    .a_i (in_data), .b_i (max_q),
    .gt_o(max_gt), .eq_o(max_eq), .lt_o(max_lt)
  );

  comp #(.N(N)) u_cmp_min (
    .a_i (in_data), .b_i (min_q),
    .gt_o(min_gt), .eq_o(min_eq), .lt_o(min_lt)
  );

  assign cmp_unused = &{max_lt, max_eq, min_gt, min_eq};

  // in_ready is gated by rst_n so nothing is accepted while reset is asserted
  assign in_ready  = rst_n && (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign accept_s  = in_valid && in_ready;
  assign out_max   = max_q;
  assign out_min   = min_q;
  assign out_count = cnt_q;

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    min_d   = min_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = EMPTY;
      cnt_d   = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept_s) begin
            max_d   = in_data;
            min_d   = in_data;
            cnt_d   = CNT_W'(1);
            state_d = (WIN == 1) ? HOLD : ACC;
          end else begin
            state_d = EMPTY;
          end
        end
        ACC: begin
          if (accept_s) begin
            if (max_gt) max_d = in_data;
            else        max_d = max_q;
            if (min_lt) min_d = in_data;
            else        min_d = min_q;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(WIN)) state_d = HOLD;
            else                      state_d = ACC;
          end else begin
            state_d = ACC;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = EMPTY;
            cnt_d   = '0;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d = EMPTY;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      max_q   <= '0;
      min_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      min_q   <= min_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef WINDOW_MINMAX_TIES_EN
  logic [CNT_W-1:0] ties_q, ties_d;

  assign out_max_ties = ties_q;

  // Ties restart at 1 whenever the max is (re)loaded, count up on equal samples
  always_comb begin
    ties_d = ties_q;
    if (clear) begin
      ties_d = '0;
    end else if (accept_s && (state_q == EMPTY)) begin
      ties_d = CNT_W'(1);
    end else if (accept_s && (state_q == ACC)) begin
      if (max_gt)      ties_d = CNT_W'(1);
      else if (max_eq) ties_d = ties_q + CNT_W'(1);
      else             ties_d = ties_q;
    end else begin
      ties_d = ties_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ties_q <= '0;
    else        ties_q <= ties_d;
  end
`endif

endmodule

// File: tb/tb_window_minmax.sv
// Table-driven self-checking bench for window_minmax with WIN=4, N=8.
module tb_window_minmax;

  localparam int N     = 8;
  localparam int WIN   = 4;
  localparam int CNT_W = $clog2(WIN + 1);

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_max;
  logic [N-1:0]     out_min;
  logic [CNT_W-1:0] out_count;
`ifdef WINDOW_MINMAX_TIES_EN
  logic [CNT_W-1:0] out_max_ties;
`endif

  window_minmax #(.N(N), .WIN(WIN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_max  (out_max),
    .out_min  (out_min),
    .out_count(out_count)
`ifdef WINDOW_MINMAX_TIES_EN
    ,
    .out_max_ties(out_max_ties)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       vld;
    logic [7:0] data;
    logic       clr;
    logic       ordy;
    logic       e_rdy;
    logic       e_ov;
    logic [7:0] e_max;
    logic [7:0] e_min;
    logic [2:0] e_cnt;
    logic [2:0] e_ties;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input string nm, input logic v, input logic [7:0] d,
                     input logic c, input logic r, input logic er, input logic ev,
                     input logic [7:0] emx, input logic [7:0] emn,
                     input logic [2:0] ec, input logic [2:0] et);
    vec_t t;
    t.name = nm; t.vld = v; t.data = d; t.clr = c; t.ordy = r;
    t.e_rdy = er; t.e_ov = ev; t.e_max = emx; t.e_min = emn;
    t.e_cnt = ec; t.e_ties = et;
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input logic er, input logic ev,
                           input logic [7:0] emx, input logic [7:0] emn,
                           input logic [2:0] ec, input logic [2:0] et);
    chk({nm, ".in_ready"},  32'(in_ready),  32'(er));
    chk({nm, ".out_valid"}, 32'(out_valid), 32'(ev));
    chk({nm, ".out_max"},   32'(out_max),   32'(emx));
    chk({nm, ".out_min"},   32'(out_min),   32'(emn));
    chk({nm, ".out_count"}, 32'(out_count), 32'(ec));
`ifdef WINDOW_MINMAX_TIES_EN
    chk({nm, ".out_max_ties"}, 32'(out_max_ties), 32'(et));
`else
    if (et === 3'bxxx) $display("unexpected x in tie expectation for %s", nm);
`endif
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic c, input logic r);
    in_valid = v; in_data = d; clear = c; out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

    //  name       v     data   clr   ordy  rdy   ov    max    min    cnt   ties
    add("b5",      1'b1, 8'd5,  1'b0, 1'b0, 1'b1, 1'b0, 8'd5,  8'd5,  3'd1, 3'd1);
    add("b3",      1'b1, 8'd3,  1'b0, 1'b0, 1'b1, 1'b0, 8'd5,  8'd3,  3'd2, 3'd1);
    add("b9",      1'b1, 8'd9,  1'b0, 1'b0, 1'b1, 1'b0, 8'd9,  8'd3,  3'd3, 3'd1);
    add("b9b",     1'b1, 8'd9,  1'b0, 1'b0, 1'b0, 1'b1, 8'd9,  8'd3,  3'd4, 3'd2);
    for (int i = 0; i < 5; i++)
      add("bp",    1'b1, 8'd77, 1'b0, 1'b0, 1'b0, 1'b1, 8'd9,  8'd3,  3'd4, 3'd2);
    add("bp_hs",   1'b1, 8'd77, 1'b0, 1'b1, 1'b1, 1'b0, 8'd9,  8'd3,  3'd0, 3'd2);
    add("eq1",     1'b1, 8'd7,  1'b0, 1'b0, 1'b1, 1'b0, 8'd7,  8'd7,  3'd1, 3'd1);
    add("eq2",     1'b1, 8'd7,  1'b0, 1'b0, 1'b1, 1'b0, 8'd7,  8'd7,  3'd2, 3'd2);
    add("eq3",     1'b1, 8'd7,  1'b0, 1'b0, 1'b1, 1'b0, 8'd7,  8'd7,  3'd3, 3'd3);
    add("eq4",     1'b1, 8'd7,  1'b0, 1'b0, 1'b0, 1'b1, 8'd7,  8'd7,  3'd4, 3'd4);
    add("eq_hs",   1'b0, 8'd0,  1'b0, 1'b1, 1'b1, 1'b0, 8'd7,  8'd7,  3'd0, 3'd4);
    add("c200",    1'b1, 8'd200,1'b0, 1'b0, 1'b1, 1'b0, 8'd200,8'd200,3'd1, 3'd1);
    add("c1",      1'b1, 8'd1,  1'b0, 1'b0, 1'b1, 1'b0, 8'd200,8'd1,  3'd2, 3'd1);
    add("clr",     1'b1, 8'd50, 1'b1, 1'b0, 1'b1, 1'b0, 8'd200,8'd1,  3'd0, 3'd0);
    add("w1",      1'b1, 8'd1,  1'b0, 1'b0, 1'b1, 1'b0, 8'd1,  8'd1,  3'd1, 3'd1);
    add("w2",      1'b1, 8'd2,  1'b0, 1'b0, 1'b1, 1'b0, 8'd2,  8'd1,  3'd2, 3'd1);
    add("w3",      1'b1, 8'd3,  1'b0, 1'b0, 1'b1, 1'b0, 8'd3,  8'd1,  3'd3, 3'd1);
    add("w4",      1'b1, 8'd4,  1'b0, 1'b0, 1'b0, 1'b1, 8'd4,  8'd1,  3'd4, 3'd1);
    add("clr_hold",1'b0, 8'd0,  1'b1, 1'b0, 1'b1, 1'b0, 8'd4,  8'd1,  3'd0, 3'd0);
    add("xFF",     1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 3'd1, 3'd1);
    add("idle1",   1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 3'd1, 3'd1);
    add("x00",     1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'h00, 3'd2, 3'd1);
    for (int i = 0; i < 3; i++)
      add("idle3", 1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'h00, 3'd2, 3'd1);
    add("x80",     1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'h00, 3'd3, 3'd1);
    add("x01",     1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 3'd4, 3'd1);
    add("x_hs",    1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h00, 3'd0, 3'd1);

    // reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_all("reset", 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 3'd0);
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check_all("post_reset", 1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 3'd0);

    foreach (vecs[i]) begin
      step(vecs[i].vld, vecs[i].data, vecs[i].clr, vecs[i].ordy);
      check_all(vecs[i].name, vecs[i].e_rdy, vecs[i].e_ov, vecs[i].e_max,
                vecs[i].e_min, vecs[i].e_cnt, vecs[i].e_ties);
    end

    // reset mid-window after two accepts
    step(1'b1, 8'd10, 1'b0, 1'b0);
    step(1'b1, 8'd20, 1'b0, 1'b0);
    check_all("pre_rst", 1'b1, 1'b0, 8'd20, 8'd10, 3'd2, 3'd1);
    rst_n = 1'b0;
    step(1'b1, 8'd30, 1'b0, 1'b0);
    check_all("mid_rst", 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 3'd0);
    rst_n = 1'b1;
    step(1'b0, 8'd0, 1'b0, 1'b0);
    check_all("rst_rel", 1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 3'd0);
    step(1'b1, 8'd4, 1'b0, 1'b0);
    step(1'b1, 8'd3, 1'b0, 1'b0);
    step(1'b1, 8'd2, 1'b0, 1'b0);
    check_all("fresh3", 1'b1, 1'b0, 8'd4, 8'd2, 3'd3, 3'd1);
    step(1'b1, 8'd1, 1'b0, 1'b0);
    check_all("fresh4", 1'b0, 1'b1, 8'd4, 8'd1, 3'd4, 3'd1);
    // clear and out_ready together in HOLD: clear wins, result dropped
    step(1'b1, 8'd99, 1'b1, 1'b1);
    check_all("clr_hs", 1'b1, 1'b0, 8'd4, 8'd1, 3'd0, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
